// File: rtl/dcache_mem_stage.sv
// Memory-stage data cache: direct-mapped, write-through, no-write-allocate, 4-word lines.
// Load hits return data in the same cycle; misses refill one word per memory beat.
module dcache_mem_stage #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  state_t                  r_state, w_next;
  logic [1:0]              r_cnt;
  logic [LINES-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [31:0]             r_data [LINES][4];
  logic [15:0]             r_miss_cnt;

  logic [INDEX_BITS-1:0]   w_idx;
  logic [1:0]              w_word;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic                    w_load_only;
  logic                    w_miss_start;
  logic                    w_beat;
  logic                    w_last_beat;
  logic                    w_wr_done;
  logic                    w_unused;

  logic [31:0]             w_rdata;
  logic                    w_stall;
  logic                    w_mem_rd;
  logic                    w_mem_wr;
  logic [31:0]             w_mem_addr;
  logic [31:0]             w_mem_wdata;

  assign w_idx       = req_addr[3+INDEX_BITS:4];
  assign w_word      = req_addr[3:2];
  assign w_tag       = req_addr[31:4+INDEX_BITS];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_load_only = req_load && !req_store;
  assign w_unused    = ^req_addr[1:0];

  assign w_miss_start = (r_state == S_IDLE) && w_load_only && !w_hit;
  assign w_beat       = (r_state == S_REFILL) && mem_ready;
  assign w_last_beat  = w_beat && (r_cnt == 2'd3);
  assign w_wr_done    = (r_state == S_WRITE) && mem_ready;

  always_comb begin
    w_next      = r_state;
    w_rdata     = 32'h0;
    w_stall     = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_addr  = 32'h0;
    w_mem_wdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        // a store wins over a simultaneous load
        if (req_store) begin
          w_stall = 1'b1;
          w_next  = S_WRITE;
        end else if (req_load) begin
          if (w_hit) begin
            w_rdata = r_data[w_idx][w_word];
          end else begin
            w_stall = 1'b1;
            w_next  = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        w_mem_rd   = 1'b1;
        w_mem_addr = {w_tag, w_idx, r_cnt, 2'b00};
        w_stall    = 1'b1;
        if (w_last_beat) w_next = S_IDLE;
      end
      S_WRITE: begin
        w_mem_wr    = 1'b1;
        w_mem_addr  = {req_addr[31:2], 2'b00};
        w_mem_wdata = req_wdata;
        w_stall     = !mem_ready;
        if (mem_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_valid    <= '0;
      r_miss_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_miss_start) begin
        r_cnt      <= 2'd0;
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 2'd1;
      end
      // valid only on the final beat, so an interrupted refill leaves the line invalid
      if (w_last_beat) r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) r_data[w_idx][r_cnt] <= mem_rdata;
    if (w_last_beat) r_tag[w_idx] <= w_tag;
    if (w_wr_done && w_hit) r_data[w_idx][w_word] <= req_wdata;
  end

  // every output is forced low while reset is held
  assign rdata      = rst_n ? w_rdata     : 32'h0;
  assign stall      = rst_n ? w_stall     : 1'b0;
  assign mem_rd     = rst_n ? w_mem_rd    : 1'b0;
  assign mem_wr     = rst_n ? w_mem_wr    : 1'b0;
  assign mem_addr   = rst_n ? w_mem_addr  : 32'h0;
  assign mem_wdata  = rst_n ? w_mem_wdata : 32'h0;
  assign miss_count = rst_n ? r_miss_cnt  : 16'h0;

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Scoreboard bench for dcache_mem_stage: stimulus queues expected memory beats and
// load data; a negedge monitor pops and compares whenever the DUT presents one.
module tb_dcache_mem_stage;

  localparam int K_RD    = 1;
  localparam int K_WR    = 2;
  localparam int K_RDATA = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_load, req_store;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rdata;
  logic        stall, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [15:0] miss_count;

  logic [31:0] bmem [0:1023];
  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  dcache_mem_stage #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_load(req_load), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata), .stall(stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .miss_count(miss_count)
  );

  assign mem_rdata = bmem[mem_addr[11:2]];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void pop_cmp(int kind, logic [31:0] addr, logic [31:0] data);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: kind %0d addr %h data %h with empty queue", kind, addr, data);
      return;
    end
    e = q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind != K_RDATA) chk("mem_addr", addr, e.addr);
    if (kind != K_RD)    chk("data", data, e.data);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd && mem_ready) pop_cmp(K_RD, mem_addr, 32'h0);
      if (mem_wr && mem_ready) pop_cmp(K_WR, mem_addr, mem_wdata);
      if (req_load && !req_store && !stall) pop_cmp(K_RDATA, 32'h0, rdata);
    end
  end

  task automatic push(int kind, logic [31:0] addr, logic [31:0] data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    q.push_back(e);
  endtask

  // exp_stall = 0 means hit; otherwise a full refill of the line is expected
  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input int exp_stall);
    int n;
    bit done;
    logic [31:0] line;
    line = {a[31:4], 4'h0};
    if (exp_stall > 0)
      for (int w = 0; w < 4; w++) push(K_RD, line + 32'(w * 4), 32'h0);
    push(K_RDATA, 32'h0, exp);
    @(posedge clk); #1;
    req_load = 1'b1; req_store = 1'b0; req_addr = a; mem_ready = 1'b1;
    n = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stall) begin done = 1'b1; break; end
      if (n == 0) chk("rdata_during_stall", rdata, 32'h0);
      n++;
    end
    if (!done) begin n_checks++; $display("FAIL load_timeout: stall still high after 40 cycles, expected release"); end
    @(posedge clk); #1;
    req_load = 1'b0; mem_ready = 1'b0;
    chk("load_stall_cycles", 32'(n), 32'(exp_stall));
  endtask

  // ready_delay < 0: mem_ready held high from the request cycle onward
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int ready_delay,
                          input bit with_load, input int exp_stall);
    int n, k;
    bit done;
    push(K_WR, {a[31:2], 2'b00}, d);
    @(posedge clk); #1;
    req_store = 1'b1; req_load = with_load; req_addr = a; req_wdata = d;
    n = 0; k = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      mem_ready = (ready_delay < 0) || (k >= 1 + ready_delay);
      @(negedge clk);
      if (!stall) begin done = 1'b1; break; end
      n++;
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin n_checks++; $display("FAIL store_timeout: stall still high after 40 cycles, expected release"); end
    bmem[a[11:2]] = d;
    @(posedge clk); #1;
    req_store = 1'b0; req_load = 1'b0; mem_ready = 1'b0;
    chk("store_stall_cycles", 32'(n), 32'(exp_stall));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) bmem[i] = 32'h0;
    for (int w = 0; w < 4; w++) begin
      bmem[(32'h100 >> 2) + w] = 32'hA0 + 32'(w);
      bmem[(32'h500 >> 2) + w] = 32'hB0 + 32'(w);
    end
    rst_n = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0;

    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_miss_count", 32'(miss_count), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: cold miss, refill A0..A3, critical word A1
    do_load(32'h104, 32'hA1, 5);
    chk("miss_after_t1", 32'(miss_count), 32'd1);
    // 2: hit in the freshly filled line
    do_load(32'h108, 32'hA2, 0);
    chk("miss_after_t2", 32'(miss_count), 32'd1);
    // 3: store hit with slow memory, then read it back
    do_store(32'h104, 32'hDEAD, 2, 1'b0, 3);
    do_load(32'h104, 32'hDEAD, 0);
    // 4: store miss writes through without allocating
    do_store(32'h504, 32'h1234, -1, 1'b0, 1);
    do_load(32'h104, 32'hDEAD, 0);
    chk("miss_after_t4", 32'(miss_count), 32'd1);
    // 5: conflicting lines evict each other
    do_load(32'h504, 32'h1234, 5);
    chk("miss_after_t5a", 32'(miss_count), 32'd2);
    do_load(32'h104, 32'hDEAD, 5);
    chk("miss_after_t5b", 32'(miss_count), 32'd3);
    // simultaneous load and store behaves as a store
    do_store(32'h108, 32'h5555, 0, 1'b1, 1);
    do_load(32'h108, 32'h5555, 0);
    chk("miss_after_both", 32'(miss_count), 32'd3);

    // 6: evict 0x104, then reset two beats into its refill
    do_load(32'h504, 32'h1234, 5);
    chk("miss_before_rst", 32'(miss_count), 32'd4);
    push(K_RD, 32'h100, 32'h0);
    push(K_RD, 32'h104, 32'h0);
    @(posedge clk); #1;
    req_load = 1'b1; req_addr = 32'h104; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 32'(stall), 32'h0);
    chk("midrst_mem_rd", 32'(mem_rd), 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_miss_count", 32'(miss_count), 32'h0);
    @(posedge clk); #1;
    req_load = 1'b0; mem_ready = 1'b0; rst_n = 1'b1;
    do_load(32'h104, 32'hDEAD, 5);
    chk("miss_after_rst", 32'(miss_count), 32'd1);
    do_load(32'h100, 32'hA0, 0);

    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_mem_stage.md
# dcache_mem_stage

Memory-stage responder for the load/store requests launched by the EX/MEM pipeline register. It is a direct-mapped, write-through, no-write-allocate data cache with 4-word lines. It serves load hits in the same cycle and refills missing lines from main memory with a one-word-per-beat handshake. It holds the pipeline with `stall` during a refill or a store write-through.

## Interface
- `INDEX_BITS`, 6, line index width (2^INDEX_BITS lines). Address split: [1:0] byte (ignored), [3:2] word, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_load` in 1: load request from EX/MEM.
- `req_store` in 1: store request from EX/MEM.
- `req_addr` in 32: byte address (ALU result).
- `req_wdata` in 32: store data.
- `rdata` out 32: load data, valid when `req_load && !stall`; 0 otherwise.
- `stall` out 1: freezes the pipeline; the requester holds `req_*` stable while it is 1.
- `mem_rd` / `mem_wr` out 1: main-memory read/write request.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, sampled when `mem_ready`=1.
- `mem_ready` in 1: beat accept / complete.
- `miss_count` out 16: load-miss counter; wraps modulo 2^16.

## Operation
- Storage: `valid`[lines], `tag`[lines], `data`[lines][4]. Hit = `valid[idx] && tag[idx]==req tag`.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, no request: `stall`=0, memory outputs 0.
- IDLE, load hit: `rdata`=data[idx][word] combinationally, `stall`=0, state stays IDLE.
- IDLE, load miss:
  - `stall`=1 in the same cycle.
  - Next state REFILL, beat counter `cnt`=0.
  - `miss_count` increments on that edge.
- REFILL:
  - `mem_rd`=1, `mem_addr`={tag,idx,cnt,2'b00}, `stall`=1.
  - On each `mem_ready`=1: data[idx][cnt]<=`mem_rdata`, `cnt`++.
  - On the beat with `cnt`==3: valid[idx]<=1, tag[idx]<=req tag, next state IDLE.
  - The held request then hits in IDLE.
- IDLE, store (hit or miss): `stall`=1; next state WRITE.
- WRITE:
  - `mem_wr`=1, `mem_addr`={req_addr[31:2],2'b00}, `mem_wdata`=`req_wdata`.
  - While `mem_ready`=0: `stall`=1.
  - Cycle `mem_ready`=1: `stall`=0 (pipeline advances); on a hit, data[idx][word]<=`req_wdata`; on a miss, no allocation; next state IDLE.
- Simultaneous `req_load`&`req_store`: treated as a store.
- `mem_ready` in IDLE is ignored.
- Reset: valid bits cleared, state IDLE, `cnt`=0, `miss_count`=0. All outputs 0 while `rst_n`=0.
- Reset mid-refill: the refill is abandoned and the line stays invalid, because valid is set only on the final beat.

## Timing
- Load hit latency: 0 cycles; no stall.
- Load miss: `stall` is high for 1 + N cycles, where N is the number of REFILL cycles (minimum 4). Data is available in the following IDLE cycle.
- Store: `stall` is high from the IDLE cycle until, but not including, the cycle `mem_ready`=1 in WRITE. Minimum 1 stall cycle.
- Memory handshake: request signals are held constant until `mem_ready`. One word is transferred per ready cycle. `mem_addr` advances the cycle after each accepted beat.

## Test plan
All addresses assume INDEX_BITS=6.
1. Reset, then load 0x104 with `mem_ready`=1 every cycle and `mem_rdata` 0xA0..0xA3 → `mem_rd` beats at 0x100/0x104/0x108/0x10C; `stall` high 5 cycles; 6th cycle `rdata`=0xA1, `stall`=0; `miss_count`=1.
2. Then load 0x108 → hit in the same cycle, `rdata`=0xA2, `mem_rd` stays 0, `miss_count`=1.
3. Store 0x104←0xDEAD with `mem_ready` delayed 3 cycles → `mem_wr`=1, `mem_addr`=0x104, `stall`=1 for 3 cycles, 0 on the ready cycle. Next load 0x104 hits with `rdata`=0xDEAD.
4. Store 0x504←0x1234 (index 0x10, tag 1, miss) → write-through only. Load 0x104 still hits with 0xDEAD, `miss_count` unchanged.
5. Load 0x504 (conflict) → refill, `miss_count`=2. Then load 0x104 misses again, `miss_count`=3.
6. Assert `rst_n`=0 after 2 refill beats of load 0x104 → outputs 0 immediately. After release, load 0x104 misses and refills all 4 words; `miss_count` restarts at 1.
